// File: rtl/vec_mem_bridge.sv
// ----------------------------------------------------------------------------
// vec_mem_bridge
//   Buffers vector LSU load/store requests in a small FIFO and issues them on a
//   valid/ready memory bus. At most MAX_OUTST requests are in flight. In-order
//   responses come back to the LSU as a registered load-data pulse or a
//   store-done pulse.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   lsu2mem_addr        request address
//   ld_req / st_req     load / store request (both high -> stored as a store and flagged)
//   lsu2mem_data        store data
//   wr_strobe           store byte enables
//   lsu_ready           bridge can accept a request this cycle (FIFO not full)
//   mem2lsu_data        last load data; holds between pulses
//   mem2lsu_valid       1-cycle pulse, mem2lsu_data valid
//   st_done             1-cycle pulse, store acknowledged
//   mem_req_*           memory request channel, driven from the FIFO head
//   mem_rsp_valid/rdata in-order response; always accepted
//   bridge_err          1-cycle pulse on protocol error
//   idle                FIFO empty and nothing outstanding
//
// Optional feature
//   VEC_MEM_BRIDGE_ALIGN_CHECK_EN: when defined, a request whose address is not
//   aligned to the data bus width is consumed, dropped and flagged on bridge_err.
// ----------------------------------------------------------------------------
module vec_mem_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     lsu2mem_addr,
    input  logic                  ld_req,
    input  logic                  st_req,
    input  logic [DATA_W-1:0]     lsu2mem_data,
    input  logic [DATA_W/8-1:0]   wr_strobe,
    output logic                  lsu_ready,
    output logic [DATA_W-1:0]     mem2lsu_data,
    output logic                  mem2lsu_valid,
    output logic                  st_done,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_strb,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,
    output logic                  bridge_err,
    output logic                  idle
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(REQ_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int TAG_IW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } req_t;

    // Storage
    req_t        fifo_mem [REQ_DEPTH];
    logic        tag_mem  [MAX_OUTST];   // 1 = store, 0 = load, in issue order

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TAG_IW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              ld_valid_q, ld_valid_d;
    logic              st_done_q, st_done_d;
    logic              err_q, err_d;

    logic fifo_empty, fifo_full, accept, push, issue, rsp_ok, misaligned;
    req_t head, new_entry;

    function automatic logic [TAG_IW-1:0] next_tag(input logic [TAG_IW-1:0] idx);
        return (idx == TAG_IW'(MAX_OUTST - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign lsu_ready = !fifo_full;
    assign idle      = fifo_empty && (outst_q == '0);
    assign accept    = (ld_req || st_req) && lsu_ready;

`ifdef VEC_MEM_BRIDGE_ALIGN_CHECK_EN
    localparam int OFF_W = (STRB_W > 1) ? $clog2(STRB_W) : 1;
    assign misaligned = (STRB_W > 1) && accept && (lsu2mem_addr[OFF_W-1:0] != '0);
`else
    assign misaligned = 1'b0;
`endif

    assign push = accept && !misaligned;

    // A simultaneous ld_req/st_req is treated as a store; loads carry no byte enables.
    assign new_entry.we    = st_req;
    assign new_entry.addr  = lsu2mem_addr;
    assign new_entry.wdata = lsu2mem_data;
    assign new_entry.strb  = st_req ? wr_strobe : '0;

    // Issue side: the head stays put until the handshake, so the bus sees a stable request.
    assign head          = fifo_mem[rd_ptr_q[IDX_W-1:0]];
    assign mem_req_valid = !fifo_empty && (outst_q < CNT_W'(MAX_OUTST));
    assign mem_req_we    = mem_req_valid && head.we;
    assign mem_req_addr  = mem_req_valid ? head.addr  : '0;
    assign mem_req_wdata = mem_req_valid ? head.wdata : '0;
    assign mem_req_strb  = mem_req_valid ? head.strb  : '0;

    assign issue  = mem_req_valid && mem_req_ready;
    assign rsp_ok = mem_rsp_valid && (outst_q != '0);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        outst_d    = outst_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        st_done_d  = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            tag_wr_d = next_tag(tag_wr_q);
        end
        if (rsp_ok) begin
            tag_rd_d = next_tag(tag_rd_q);
            if (tag_mem[tag_rd_q]) begin
                st_done_d = 1'b1;
            end else begin
                ld_valid_d = 1'b1;
                ld_data_d  = mem_rsp_rdata;
            end
        end

        // Issue and response in the same cycle leave the count unchanged.
        unique case ({issue, rsp_ok})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        err_d = (accept && ld_req && st_req) || misaligned || (mem_rsp_valid && (outst_q == '0));
    end

    // NOTE: storage arrays are not reset; the cleared pointers alone mark every entry invalid.
    always_ff @(posedge clk) begin
        if (push)  fifo_mem[wr_ptr_q[IDX_W-1:0]] <= new_entry;
        if (issue) tag_mem[tag_wr_q]             <= head.we;
    end

    // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            outst_q    <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            outst_q    <= outst_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            st_done_q  <= st_done_d;
            err_q      <= err_d;
        end
    end

    assign mem2lsu_data  = ld_data_q;
    assign mem2lsu_valid = ld_valid_q;
    assign st_done       = st_done_q;
    assign bridge_err    = err_q;

endmodule

// File: tb/tb_vec_mem_bridge.sv
// ----------------------------------------------------------------------------
// tb_vec_mem_bridge
//   Directed stimulus for vec_mem_bridge. Expected memory requests, LSU
//   responses and error pulses are queued when stimulus is issued; a monitor
//   on the falling clock edge pops and compares whenever the DUT presents them.
// ----------------------------------------------------------------------------
module tb_vec_mem_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int STRB_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] lsu2mem_addr;
    logic              ld_req, st_req;
    logic [DATA_W-1:0] lsu2mem_data;
    logic [STRB_W-1:0] wr_strobe;
    logic              lsu_ready;
    logic [DATA_W-1:0] mem2lsu_data;
    logic              mem2lsu_valid, st_done;
    logic              mem_req_valid, mem_req_ready, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [STRB_W-1:0] mem_req_strb;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
    logic              bridge_err, idle;

    vec_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(4), .MAX_OUTST(4)) dut (
        .clk(clk), .reset(reset),
        .lsu2mem_addr(lsu2mem_addr), .ld_req(ld_req), .st_req(st_req),
        .lsu2mem_data(lsu2mem_data), .wr_strobe(wr_strobe), .lsu_ready(lsu_ready),
        .mem2lsu_data(mem2lsu_data), .mem2lsu_valid(mem2lsu_valid), .st_done(st_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_strb(mem_req_strb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .bridge_err(bridge_err), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } req_exp_t;

    typedef struct {
        bit                is_st;
        logic [DATA_W-1:0] data;
    } rsp_exp_t;

    req_exp_t exp_req[$];
    rsp_exp_t exp_rsp[$];
    int       err_pending = 0;
    int       checks      = 0;
    int       failures    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted; queue what it should produce.
    task automatic send(input bit ld, input bit st, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb,
                        input logic [DATA_W-1:0] rdata);
        bit mis;
        int n;
        mis = 1'b0;
`ifdef VEC_MEM_BRIDGE_ALIGN_CHECK_EN
        mis = (addr[3:0] != 4'h0);
`endif
        ld_req = ld; st_req = st; lsu2mem_addr = addr; lsu2mem_data = data; wr_strobe = strb;
        n = 0;
        while (!lsu_ready && n < 50) begin
            step();
            n++;
        end
        if (!lsu_ready) begin
            check("send_accept_timeout", lsu_ready, 1'b1);
        end else begin
            if (mis || (ld && st)) err_pending++;
            if (!mis) begin
                exp_req.push_back('{we: st, addr: addr, wdata: data, strb: st ? strb : '0});
                exp_rsp.push_back('{is_st: st, data: rdata});
            end
            step();
        end
        ld_req = 1'b0; st_req = 1'b0;
    endtask

    task automatic rsp(input logic [DATA_W-1:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = data;
        step();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(idle && exp_rsp.size() == 0) && n < 100) begin
            step();
            n++;
        end
        check(name, idle && exp_rsp.size() == 0, 1'b1);
    endtask

    // Monitor / scoreboard
    req_exp_t me;
    rsp_exp_t mr;
    always @(negedge clk) begin
        if (reset) begin
            if (mem_req_valid && mem_req_ready) begin
                check("mem_req_expected", exp_req.size() != 0, 1'b1);
                if (exp_req.size() != 0) begin
                    me = exp_req.pop_front();
                    check("mem_req_we", mem_req_we, me.we);
                    check("mem_req_addr", mem_req_addr, me.addr);
                    check("mem_req_strb", mem_req_strb, me.strb);
                    if (me.we) check("mem_req_wdata", mem_req_wdata, me.wdata);
                end
            end
            if (mem2lsu_valid || st_done) begin
                check("lsu_rsp_expected", exp_rsp.size() != 0, 1'b1);
                if (exp_rsp.size() != 0) begin
                    mr = exp_rsp.pop_front();
                    check("lsu_rsp_kind", {st_done, mem2lsu_valid}, {mr.is_st, !mr.is_st});
                    if (!mr.is_st) check("lsu_rsp_data", mem2lsu_data, mr.data);
                end
            end
            if (bridge_err) begin
                check("bridge_err_expected", err_pending > 0, 1'b1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ld_req = 1'b0; st_req = 1'b0; lsu2mem_addr = '0; lsu2mem_data = '0;
        wr_strobe = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        repeat (3) step();

        // Reset state
        check("rst_lsu_ready", lsu_ready, 1'b1);
        check("rst_idle", idle, 1'b1);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_ld_valid", mem2lsu_valid, 1'b0);
        check("rst_st_done", st_done, 1'b0);
        check("rst_err", bridge_err, 1'b0);
        check("rst_ld_data", mem2lsu_data, 128'h0);
        reset = 1'b1;
        step();

        // T1: single load, minimum latency
        mem_req_ready = 1'b1;
        send(1, 0, 32'h100, '0, 16'hFFFF, {16{8'hA5}});
        check("t1_req_valid_n1", mem_req_valid, 1'b1);
        check("t1_req_addr_n1", mem_req_addr, 32'h100);
        step();
        rsp({16{8'hA5}});
        check("t1_ld_valid_n3", mem2lsu_valid, 1'b1);
        check("t1_ld_data_n3", mem2lsu_data, {16{8'hA5}});
        check("t1_idle", idle, 1'b1);
        step();
        check("t1_ld_pulse_1cyc", mem2lsu_valid, 1'b0);
        check("t1_data_hold", mem2lsu_data, {16{8'hA5}});

        // T2: memory stalled, FIFO fills after 4 stores
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(0, 1, 32'h1000 + 32'(16 * i), {4{32'hC0DE0000 + 32'(i)}}, 16'h000F << (4 * i), '0);
        st_req = 1'b1; lsu2mem_addr = 32'h1040;
        check("t2_full_not_ready", lsu_ready, 1'b0);
        st_req = 1'b0;
        step(); step();
        check("t2_head_stable_valid", mem_req_valid, 1'b1);
        check("t2_head_stable_addr", mem_req_addr, 32'h1000);
        mem_req_ready = 1'b1;
        repeat (4) step();
        check("t2_all_issued", mem_req_valid, 1'b0);
        repeat (4) rsp('0);
        wait_drain("t2_drain");

        // T3: outstanding limit of 4
        for (int i = 1; i <= 6; i++)
            send(1, 0, 32'h2000 + 32'(16 * i), '0, 16'hFFFF, 128'(i));
        repeat (3) step();
        check("t3_valid_blocked", mem_req_valid, 1'b0);
        check("t3_not_idle", idle, 1'b0);
        check("t3_lsu_ready", lsu_ready, 1'b1);
        for (int i = 1; i <= 6; i++) rsp(128'(i));
        wait_drain("t3_drain");

        // T4: mixed ld/st/ld, response overlaps with issue
        send(1, 0, 32'h3000, '0, 16'hFFFF, {16{8'h11}});
        send(0, 1, 32'h3010, {4{32'hFEEDBEEF}}, 16'hF0F0, '0);
        send(1, 0, 32'h3020, '0, 16'hFFFF, {16{8'h33}});
        rsp({16{8'h11}});
        rsp({16{8'h99}});
        rsp({16{8'h33}});
        wait_drain("t4_drain");

        // T5: spurious response, then ld&st together
        err_pending++;
        rsp(128'hDEAD);
        check("t5_spurious_err", bridge_err, 1'b1);
        check("t5_no_ld_pulse", mem2lsu_valid, 1'b0);
        send(1, 1, 32'h4000, {4{32'h12345678}}, 16'h00FF, '0);
        check("t5_both_err", bridge_err, 1'b1);
        step();
        rsp('0);
        wait_drain("t5_drain");

        // T6: reset with 2 outstanding and 2 queued
        send(1, 0, 32'h5000, '0, 16'hFFFF, '0);
        send(1, 0, 32'h5010, '0, 16'hFFFF, '0);
        step();
        mem_req_ready = 1'b0;
        send(1, 0, 32'h5020, '0, 16'hFFFF, '0);
        send(1, 0, 32'h5030, '0, 16'hFFFF, '0);
        check("t6_busy", idle, 1'b0);
        reset = 1'b0;
        #1;
        exp_req.delete();
        exp_rsp.delete();
        check("t6_rst_req_valid", mem_req_valid, 1'b0);
        check("t6_rst_req_addr", mem_req_addr, 32'h0);
        check("t6_rst_ld_data", mem2lsu_data, 128'h0);
        check("t6_rst_lsu_ready", lsu_ready, 1'b1);
        check("t6_rst_idle", idle, 1'b1);
        step();
        reset = 1'b1;
        step();
        check("t6_idle_after", idle, 1'b1);

        // Misaligned address: dropped with an error when the check is built in
        mem_req_ready = 1'b1;
        send(1, 0, 32'h104, '0, 16'hFFFF, {16{8'h77}});
`ifdef VEC_MEM_BRIDGE_ALIGN_CHECK_EN
        check("t6_align_err", bridge_err, 1'b1);
        check("t6_align_no_req", mem_req_valid, 1'b0);
        step();
`else
        step();
        rsp({16{8'h77}});
`endif
        send(1, 0, 32'h110, '0, 16'hFFFF, {16{8'h88}});
        step();
        rsp({16{8'h88}});
        wait_drain("t6_drain");
        repeat (2) step();

        check("end_req_queue_empty", exp_req.size(), 0);
        check("end_err_pending", err_pending, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
